dmem_mmio: RTL and testbench

//   Data-memory responder for the single-cycle MIPS core. It answers the core's

---
 rtl/dmem_mmio.sv | 64 ++++++
 tb/tb_dmem_mmio.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus MMIO page (GPIO, cycle counter, compare, sticky status) for the single-cycle core
module dmem_mmio #(
  parameter int          DEPTH   = 64,
  parameter int          GPIO_W  = 8,
  parameter logic [15:0] IO_PAGE = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              match
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] ram [DEPTH];
  logic [31:0] cycle, cmp;
  logic [GPIO_W-1:0] sync1, sync2;
  logic [1:0] status;
  logic [AW-1:0] idx;
  logic mmio, aligned, we, misaligned, match_ev;
  logic hit_gpo, hit_gpi, hit_cyc, hit_cmp, hit_sts;
  assign mmio       = addr[31:16] == IO_PAGE;
  assign aligned    = addr[1:0] == 2'b00;
  assign we         = memwrite && aligned;
  assign misaligned = memwrite && !aligned;
  assign idx        = addr[AW+1:2];
  assign hit_gpo    = mmio && addr[15:2] == 14'd0;
  assign hit_gpi    = mmio && addr[15:2] == 14'd1;
  assign hit_cyc    = mmio && addr[15:2] == 14'd2;
  assign hit_cmp    = mmio && addr[15:2] == 14'd3;
  assign hit_sts    = mmio && addr[15:2] == 14'd4;
  assign match_ev   = cmp != 32'd0 && cycle == cmp;
  assign match      = status[0];
  always_comb
    readdata = !mmio  ? ram[idx] :
               hit_gpo ? {{(32-GPIO_W){1'b0}}, gpio_out} :
               hit_gpi ? {{(32-GPIO_W){1'b0}}, sync2} :
               hit_cyc ? cycle :
               hit_cmp ? cmp :
               hit_sts ? {30'd0, status} : 32'd0;
  // RAM is not reset, but a write coinciding with reset is still dropped
  always_ff @(posedge clk)
    if (we && !mmio && !reset) ram[idx] <= writedata;
  // match uses pre-write CYCLE/CMP; set events override a same-edge W1C clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
      cycle    <= '0;
      cmp      <= '0;
      status   <= '0;
    end else begin
      sync1  <= gpio_in;
      sync2  <= sync1;
      cycle  <= (we && hit_cyc) ? writedata : cycle + 32'd1;
      status <= (status & ~((we && hit_sts) ? writedata[1:0] : 2'b00)) | {misaligned, match_ev};
      if (we && hit_gpo) gpio_out <= writedata[GPIO_W-1:0];
      if (we && hit_cmp) cmp <= writedata;
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed checks of RAM, aliasing, GPIO sync, counter/compare/status and async reset
module tb_dmem_mmio;
  localparam logic [31:0] GPO = 32'hFFFF0000, GPI = 32'hFFFF0004, CYC = 32'hFFFF0008,
                          CMP = 32'hFFFF000C, STS = 32'hFFFF0010;
  logic clk = 1'b0, reset = 1'b1, memwrite = 1'b0, match;
  logic [31:0] addr = 32'd0, writedata = 32'd0, readdata;
  logic [7:0] gpio_in = 8'd0, gpio_out;
  int pass_cnt = 0, total = 0;

  dmem_mmio #(.DEPTH(64), .GPIO_W(8), .IO_PAGE(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .writedata(writedata),
    .readdata(readdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .match(match)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    addr = CYC;
    #3;
    chk("reset_cycle", readdata, 32'd0);
    chk("reset_gpio_out", {24'd0, gpio_out}, 32'd0);
    chk("reset_match", {31'd0, match}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    // 1: RAM write/read and aliasing
    wr(32'h10, 32'hDEADBEEF);
    rd("ram_read", 32'h10, 32'hDEADBEEF);
    rd("ram_alias", 32'h10 + 32'd256, 32'hDEADBEEF);
    // 2: GPIO out and synchronised GPIO in
    wr(GPO, 32'h1A5);
    chk("gpio_out_pin", {24'd0, gpio_out}, 32'hA5);
    rd("gpio_out_read", GPO, 32'hA5);
    gpio_in = 8'h3C;
    rd("gpio_in_0cyc", GPI, 32'h0);
    tick();
    rd("gpio_in_1cyc", GPI, 32'h0);
    tick();
    rd("gpio_in_2cyc", GPI, 32'h3C);
    // 3: compare match, W1C clear, clear racing a set
    wr(CYC, 32'd10);
    rd("cycle_written", CYC, 32'd10);
    wr(CMP, 32'd20);
    for (int i = 0; i < 9; i++) tick();
    rd("cycle_at_20", CYC, 32'd20);
    chk("match_before", {31'd0, match}, 32'd0);
    tick();
    chk("match_rise", {31'd0, match}, 32'd1);
    rd("cycle_after_match", CYC, 32'd21);
    rd("status_match", STS, 32'd1);
    wr(STS, 32'd1);
    chk("match_cleared", {31'd0, match}, 32'd0);
    wr(CYC, 32'd18);
    tick();
    tick();
    wr(STS, 32'd1);
    chk("clear_vs_set", {31'd0, match}, 32'd1);
    wr(STS, 32'd3);
    rd("status_clr_all", STS, 32'd0);
    // 4: counter wrap with CMP=0 never matches
    wr(CMP, 32'd0);
    rd("cmp_zero", CMP, 32'd0);
    wr(CYC, 32'hFFFFFFFE);
    rd("cycle_fffe", CYC, 32'hFFFFFFFE);
    tick();
    rd("cycle_ffff", CYC, 32'hFFFFFFFF);
    tick();
    rd("cycle_wrap", CYC, 32'h0);
    tick();
    rd("no_match_cmp0", STS, 32'd0);
    // 5: misaligned write dropped, sets STATUS[1]; unmapped offset
    wr(32'h20, 32'hCAFEF00D);
    wr(32'h22, 32'h12345678);
    rd("misaligned_ram", 32'h20, 32'hCAFEF00D);
    rd("misaligned_read", 32'h22, 32'hCAFEF00D);
    rd("status_misalign", STS, 32'h2);
    addr = 32'h23;
    tick();
    rd("misread_no_set", STS, 32'h2);
    rd("unmapped_read", 32'hFFFF0020, 32'h0);
    wr(32'hFFFF0020, 32'hFFFFFFFF);
    rd("unmapped_wr", 32'hFFFF0020, 32'h0);
    wr(STS, 32'h2);
    rd("status_w1c", STS, 32'h0);
    // 6: async reset mid-cycle drops the in-flight write
    wr(CMP, 32'd5);
    wr(32'h1, 32'h0);
    rd("pre_reset_sts", STS, 32'h2);
    addr = 32'h10;
    writedata = 32'h11111111;
    memwrite = 1'b1;
    #3;
    reset = 1'b1;
    tick();
    memwrite = 1'b0;
    rd("rst_gpo", GPO, 32'h0);
    rd("rst_gpi", GPI, 32'h0);
    rd("rst_cycle", CYC, 32'h0);
    rd("rst_cmp", CMP, 32'h0);
    rd("rst_status", STS, 32'h0);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_gpio_pin", {24'd0, gpio_out}, 32'd0);
    reset = 1'b0;
    rd("rst_ram_kept", 32'h10, 32'hDEADBEEF);
    rd("rst_ram_kept2", 32'h20, 32'hCAFEF00D);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
